// File: rtl/rx_frame_ctrl_if.sv
// Byte-wide Rx interface between the deserialiser and the frame controller.
// The deserialiser drives it (master); the frame controller samples it (slave).
interface rx_frame_ctrl_if;
  logic       rx_soc;
  logic       rx_eoc;
  logic       rx_error;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic [2:0] rx_data_bits;

  modport master (
    output rx_soc, rx_eoc, rx_error,
    output rx_data_valid, rx_data, rx_data_bits
  );

  modport slave (
    input rx_soc, rx_eoc, rx_error,
    input rx_data_valid, rx_data, rx_data_bits
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// ISO/IEC 14443A receive frame controller: buffers one frame,
// checks CRC_A on the fly and hands it over with a ready/ack handshake.
module rx_frame_ctrl #(
  parameter  int MAX_BYTES = 16,
  localparam int LW = $clog2(MAX_BYTES + 1),
  localparam int AW = $clog2(MAX_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_enable,
  rx_frame_ctrl_if.slave rx,
  output logic          frame_ready,
  input  logic          frame_ack,
  output logic [LW-1:0] frame_len,
  output logic [2:0]    last_bits,
  output logic          crc_ok,
  output logic          overflow,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rx_abort,
  output logic          frame_dropped
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOC,
    RECEIVING,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [LW-1:0] r_count;
  logic [15:0]   r_crc;
  logic          r_ovf;
  logic [7:0]    r_buf [MAX_BYTES];
  logic          r_ready;
  logic [LW-1:0] r_frame_len;
  logic [2:0]    r_last_bits;
  logic          r_crc_ok;
  logic          r_ovf_o;
  logic [7:0]    r_rd_data;
  logic          r_abort;
  logic          r_dropped;

  logic          w_clear;
  logic          w_wr;
  logic          w_crc_upd;
  logic          w_ovf_set;
  logic          w_abort;
  logic          w_drop;
  logic          w_load;
  logic [2:0]    w_last;
  logic          w_full;
  logic [LW-1:0] w_len_nxt;
  logic          w_crc_ok_nxt;

  function automatic logic [15:0] crc_a(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
    end
    return x;
  endfunction

  assign w_full = (r_count == LW'(MAX_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_wr        = 1'b0;
    w_crc_upd   = 1'b0;
    w_ovf_set   = 1'b0;
    w_abort     = 1'b0;
    w_drop      = 1'b0;
    w_load      = 1'b0;
    w_last      = 3'd0;
    unique case (r_state)
      IDLE: begin
        if (rx_enable) w_state_nxt = WAIT_SOC;
      end
      WAIT_SOC: begin
        if (!rx_enable) begin
          w_state_nxt = IDLE;
        end else if (rx.rx_soc) begin
          w_state_nxt = RECEIVING;
          w_clear     = 1'b1;
        end
      end
      RECEIVING: begin
        if (!rx_enable) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (rx.rx_error) begin
          w_abort     = 1'b1;
          w_state_nxt = WAIT_SOC;
        end else if (rx.rx_soc) begin
          w_clear = 1'b1;
        end else if (rx.rx_data_valid && rx.rx_eoc) begin
          // partial final byte: stored but never fed to the CRC
          if (w_full) w_ovf_set = 1'b1;
          else        w_wr      = 1'b1;
          w_last      = rx.rx_data_bits;
          w_load      = 1'b1;
          w_state_nxt = DONE;
        end else if (rx.rx_data_valid) begin
          if (rx.rx_data_bits != 3'd0) begin
            w_abort     = 1'b1;
            w_state_nxt = WAIT_SOC;
          end else if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_wr      = 1'b1;
            w_crc_upd = 1'b1;
          end
        end else if (rx.rx_eoc) begin
          if (r_count == '0) begin
            w_state_nxt = WAIT_SOC;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (frame_ack) begin
          if (rx.rx_soc) begin
            w_state_nxt = RECEIVING;
            w_clear     = 1'b1;
          end else if (rx_enable) begin
            w_state_nxt = WAIT_SOC;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (rx.rx_soc) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_len_nxt = w_wr ? r_count + LW'(1) : r_count;

  // only the eoc-without-data path can yield a good CRC; it has last_bits=0
  assign w_crc_ok_nxt = (w_last == 3'd0) && (r_crc == 16'h0000) &&
                        (r_count >= LW'(3)) && !r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_crc       <= 16'h0000;
      r_ovf       <= 1'b0;
      r_ready     <= 1'b0;
      r_frame_len <= '0;
      r_last_bits <= 3'd0;
      r_crc_ok    <= 1'b0;
      r_ovf_o     <= 1'b0;
      r_rd_data   <= 8'h00;
      r_abort     <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt == DONE);
      r_abort   <= w_abort;
      r_dropped <= w_drop;
      r_rd_data <= r_buf[rd_addr];
      if (w_clear) begin
        r_count <= '0;
        r_crc   <= 16'h6363;
        r_ovf   <= 1'b0;
      end else begin
        if (w_wr)      r_count <= r_count + LW'(1);
        if (w_crc_upd) r_crc   <= crc_a(r_crc, rx.rx_data);
        if (w_ovf_set) r_ovf   <= 1'b1;
      end
      if (w_load) begin
        r_frame_len <= w_len_nxt;
        r_last_bits <= w_last;
        r_crc_ok    <= w_crc_ok_nxt;
        r_ovf_o     <= r_ovf | w_ovf_set;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_buf[r_count[AW-1:0]] <= rx.rx_data;
  end

  assign frame_ready   = r_ready;
  assign frame_len     = r_frame_len;
  assign last_bits     = r_last_bits;
  assign crc_ok        = r_crc_ok;
  assign overflow      = r_ovf_o;
  assign rd_data       = r_rd_data;
  assign rx_abort      = r_abort;
  assign frame_dropped = r_dropped;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomised self-checking bench for rx_frame_ctrl against a
// frame-level model (byte list -> length, overflow, CRC residue).
module tb_rx_frame_ctrl;
  localparam int MAXB = 16;
  localparam int LW = $clog2(MAXB + 1);
  localparam int AW = $clog2(MAXB);
  localparam int SW = LW + 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_enable = 1'b0;
  logic          frame_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          frame_ready;
  logic [LW-1:0] frame_len;
  logic [2:0]    last_bits;
  logic          crc_ok;
  logic          overflow;
  logic [7:0]    rd_data;
  logic          rx_abort;
  logic          frame_dropped;

  int checks = 0;
  int errors = 0;

  rx_frame_ctrl_if rxi ();

  rx_frame_ctrl #(.MAX_BYTES(MAXB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_enable    (rx_enable),
    .rx           (rxi.slave),
    .frame_ready  (frame_ready),
    .frame_ack    (frame_ack),
    .frame_len    (frame_len),
    .last_bits    (last_bits),
    .crc_ok       (crc_ok),
    .overflow     (overflow),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rx_abort     (rx_abort),
    .frame_dropped(frame_dropped)
  );

  always #5 clk = ~clk;

  logic [SW-1:0] st;
  assign st = {frame_ready, frame_len, last_bits, overflow, crc_ok};

  // CRC_A computed bit-serially straight from the polynomial definition
  function automatic logic [15:0] ref_crc(input logic [7:0] q[$], input int n);
    logic [15:0] c;
    logic fb;
    c = 16'h6363;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  // expected {ready, len, last_bits, overflow, crc_ok} of a received frame
  function automatic logic [SW-1:0] model(input logic [7:0] q[$], input logic [2:0] bits);
    int n;
    int len;
    logic ovf;
    logic ok;
    n = q.size();
    len = (n > MAXB) ? MAXB : n;
    ovf = (n > MAXB);
    ok = 1'b0;
    if (bits == 3'd0 && n >= 3 && !ovf)
      ok = (ref_crc(q, n - 2) == {q[n-1], q[n-2]});
    return {1'b1, LW'(len), bits, ovf, ok};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_soc();
    rxi.rx_soc = 1'b1;
    cyc();
    rxi.rx_soc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [2:0] bits, input logic eoc);
    rxi.rx_data_valid = 1'b1;
    rxi.rx_data = d;
    rxi.rx_data_bits = bits;
    rxi.rx_eoc = eoc;
    cyc();
    rxi.rx_data_valid = 1'b0;
    rxi.rx_eoc = 1'b0;
    rxi.rx_data_bits = 3'd0;
    rxi.rx_data = $urandom_range(0, 255);
  endtask

  task automatic send_eoc();
    rxi.rx_eoc = 1'b1;
    cyc();
    rxi.rx_eoc = 1'b0;
  endtask

  task automatic send_error();
    rxi.rx_error = 1'b1;
    cyc();
    rxi.rx_error = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  // frame body after soc: full bytes, then partial byte+eoc or bare eoc
  task automatic send_body(input logic [7:0] q[$], input logic [2:0] bits);
    int nf;
    nf = (bits != 3'd0) ? q.size() - 1 : q.size();
    for (int i = 0; i < nf; i++) begin
      send_byte(q[i], 3'd0, 1'b0);
      gap();
    end
    if (bits != 3'd0) send_byte(q[q.size()-1], bits, 1'b1);
    else send_eoc();
  endtask

  task automatic rx_frame(input logic [7:0] q[$], input logic [2:0] bits);
    gap();
    send_soc();
    send_body(q, bits);
  endtask

  task automatic read_buf(input int n, output logic [7:0] d[MAXB]);
    for (int i = 0; i < MAXB; i++) d[i] = 8'h00;
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i);
      cyc();
      d[i] = rd_data;
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL ack_drop frame_ready=%0b exp 0", frame_ready);
    end
  endtask

  task automatic rand_frame(output logic [7:0] q[$], output logic [2:0] bits);
    int n;
    logic [15:0] c;
    q = {};
    n = $urandom_range(1, 20);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    bits = 3'd0;
    if ($urandom_range(0, 1) == 1) begin
      c = ref_crc(q, n);
      q.push_back(c[7:0]);
      q.push_back(c[15:8]);
    end else if ($urandom_range(0, 2) == 0) begin
      bits = 3'($urandom_range(1, 7));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({st, rd_data, rx_abort, frame_dropped} !== '0) begin
      errors++;
      $display("FAIL reset st=%0h rd=%0h ab=%0b dr=%0b exp 0",
               st, rd_data, rx_abort, frame_dropped);
    end
    rst = 1'b0;
    rx_enable = 1'b1;
    cyc();
  endtask

  task automatic test_short();
    logic [7:0] q[$];
    logic [7:0] d[MAXB];
    q = {8'h26};
    rx_frame(q, 3'd7);
    checks++;
    if (st !== {1'b1, LW'(1), 3'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL short_status got %0h exp %0h", st, {1'b1, LW'(1), 3'd7, 2'b00});
    end
    read_buf(1, d);
    checks++;
    if (d[0] !== 8'h26) begin
      errors++;
      $display("FAIL short_data got %0h exp 26", d[0]);
    end
    do_ack();
  endtask

  task automatic test_hlta();
    logic [7:0] q[$];
    q = {8'h50, 8'h00, 8'h57, 8'hCD};
    rx_frame(q, 3'd0);
    checks++;
    if (st !== {1'b1, LW'(4), 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hlta_good got %0h exp %0h", st, {1'b1, LW'(4), 5'b00001});
    end
    do_ack();
    q[3] = 8'hCC;
    rx_frame(q, 3'd0);
    checks++;
    if (st !== {1'b1, LW'(4), 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hlta_bad got %0h exp %0h", st, {1'b1, LW'(4), 5'b00000});
    end
    do_ack();
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    logic [7:0] d[MAXB];
    q = {};
    for (int i = 0; i < MAXB + 1; i++) q.push_back(8'($urandom_range(0, 255)));
    rx_frame(q, 3'd0);
    checks++;
    if (st !== {1'b1, LW'(MAXB), 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_status got %0h exp %0h", st, {1'b1, LW'(MAXB), 5'b00010});
    end
    read_buf(MAXB, d);
    for (int i = 0; i < MAXB; i++) begin
      checks++;
      if (d[i] !== q[i]) begin
        errors++;
        $display("FAIL ovf_data[%0d] got %0h exp %0h", i, d[i], q[i]);
      end
    end
    do_ack();
  endtask

  task automatic test_error();
    logic [7:0] q[$];
    send_soc();
    send_byte(8'hA5, 3'd0, 1'b0);
    send_byte(8'h5A, 3'd0, 1'b0);
    send_error();
    checks++;
    if ({rx_abort, frame_ready} !== 2'b10) begin
      errors++;
      $display("FAIL err_abort ab=%0b rdy=%0b exp 1 0", rx_abort, frame_ready);
    end
    cyc();
    checks++;
    if ({rx_abort, frame_ready} !== 2'b00) begin
      errors++;
      $display("FAIL err_pulse ab=%0b rdy=%0b exp 0 0", rx_abort, frame_ready);
    end
    q = {8'h50, 8'h00, 8'h57, 8'hCD};
    rx_frame(q, 3'd0);
    checks++;
    if (st !== model(q, 3'd0) || crc_ok !== 1'b1) begin
      errors++;
      $display("FAIL err_next got %0h exp %0h", st, model(q, 3'd0));
    end
    do_ack();
  endtask

  task automatic test_violation();
    send_soc();
    send_byte(8'h11, 3'd0, 1'b0);
    send_byte(8'h22, 3'd3, 1'b0);
    checks++;
    if ({rx_abort, frame_ready} !== 2'b10) begin
      errors++;
      $display("FAIL viol_abort ab=%0b rdy=%0b exp 1 0", rx_abort, frame_ready);
    end
    send_soc();
    send_eoc();
    cyc();
    checks++;
    if ({rx_abort, frame_ready} !== 2'b00) begin
      errors++;
      $display("FAIL empty_frame ab=%0b rdy=%0b exp 0 0", rx_abort, frame_ready);
    end
  endtask

  task automatic test_held();
    logic [7:0] q[$];
    logic [7:0] q2[$];
    logic [2:0] b;
    logic [2:0] b2;
    logic [SW-1:0] s0;
    logic [7:0] d[MAXB];
    int n;
    rand_frame(q, b);
    rx_frame(q, b);
    s0 = model(q, b);
    send_soc();
    checks++;
    if ({frame_dropped, st} !== {1'b1, s0}) begin
      errors++;
      $display("FAIL held_drop dr=%0b st=%0h exp 1 %0h", frame_dropped, st, s0);
    end
    cyc();
    checks++;
    if ({frame_dropped, st} !== {1'b0, s0}) begin
      errors++;
      $display("FAIL held_pulse dr=%0b st=%0h exp 0 %0h", frame_dropped, st, s0);
    end
    n = (q.size() > MAXB) ? MAXB : q.size();
    read_buf(n, d);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (d[i] !== q[i]) begin
        errors++;
        $display("FAIL held_data[%0d] got %0h exp %0h", i, d[i], q[i]);
      end
    end
    rand_frame(q2, b2);
    rxi.rx_soc = 1'b1;
    frame_ack = 1'b1;
    cyc();
    rxi.rx_soc = 1'b0;
    frame_ack = 1'b0;
    send_body(q2, b2);
    checks++;
    if (st !== model(q2, b2)) begin
      errors++;
      $display("FAIL soc_ack_frame got %0h exp %0h", st, model(q2, b2));
    end
    n = (q2.size() > MAXB) ? MAXB : q2.size();
    read_buf(n, d);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (d[i] !== q2[i]) begin
        errors++;
        $display("FAIL soc_ack_data[%0d] got %0h exp %0h", i, d[i], q2[i]);
      end
    end
    do_ack();
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [2:0] b;
    logic [7:0] d[MAXB];
    int n;
    for (int k = 0; k < 24; k++) begin
      rand_frame(q, b);
      // back-to-back: soc lands on the cycle right after the ack
      if (k % 3 == 0) begin
        send_soc();
        send_body(q, b);
      end else begin
        rx_frame(q, b);
      end
      checks++;
      if (st !== model(q, b)) begin
        errors++;
        $display("FAIL rand%0d_status got %0h exp %0h", k, st, model(q, b));
      end
      n = (q.size() > MAXB) ? MAXB : q.size();
      read_buf(n, d);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (d[i] !== q[i]) begin
          errors++;
          $display("FAIL rand%0d_data[%0d] got %0h exp %0h", k, i, d[i], q[i]);
        end
      end
      do_ack();
    end
  endtask

  task automatic test_enable();
    logic [7:0] q[$];
    send_soc();
    send_byte(8'h33, 3'd0, 1'b0);
    rx_enable = 1'b0;
    cyc();
    checks++;
    if ({rx_abort, frame_ready} !== 2'b10) begin
      errors++;
      $display("FAIL en_abort ab=%0b rdy=%0b exp 1 0", rx_abort, frame_ready);
    end
    q = {8'h50, 8'h00, 8'h57, 8'hCD};
    rx_frame(q, 3'd0);
    cyc();
    checks++;
    if ({rx_abort, frame_ready} !== 2'b00) begin
      errors++;
      $display("FAIL en_idle ab=%0b rdy=%0b exp 0 0", rx_abort, frame_ready);
    end
    rx_enable = 1'b1;
    cyc();
  endtask

  task automatic test_reset_done();
    logic [7:0] q[$];
    q = {8'h93, 8'h20, 8'h7E};
    rx_frame(q, 3'd0);
    rd_addr = AW'(1);
    cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({st, rd_data, rx_abort, frame_dropped} !== '0) begin
      errors++;
      $display("FAIL rst_done st=%0h rd=%0h exp 0", st, rd_data);
    end
    rst = 1'b0;
    send_soc();
    send_body(q, 3'd0);
    cyc();
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle rdy=%0b exp 0", frame_ready);
    end
    q = {8'h50, 8'h00, 8'h57, 8'hCD};
    rx_frame(q, 3'd0);
    checks++;
    if (st !== model(q, 3'd0)) begin
      errors++;
      $display("FAIL rst_recover got %0h exp %0h", st, model(q, 3'd0));
    end
    do_ack();
  endtask

  initial begin
    rxi.rx_soc = 1'b0;
    rxi.rx_eoc = 1'b0;
    rxi.rx_error = 1'b0;
    rxi.rx_data_valid = 1'b0;
    rxi.rx_data = 8'h00;
    rxi.rx_data_bits = 3'd0;
    test_reset();
    test_short();
    test_hlta();
    test_overflow();
    test_error();
    test_violation();
    test_held();
    test_random();
    test_enable();
    test_reset_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
